bridge_mc: RTL

Multi-channel, parametrised successor to the single-client DRAM bridge. It accepts single-beat read/write requests from `N_CH` independent clients and arbitrates between them round-robin. Each granted request becomes one AXI4-Lite master transaction toward the DRAM model, and the response, with an error flag, is returned to the originating channel. It sits between the system's client FSMs and the `INF` AXI-Lite DRAM port; one transaction is outstanding at a time.

---
 rtl/bridge_mc.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/bridge_mc.sv
// bridge_mc: round-robin arbiter of N_CH single-beat clients onto one AXI4-Lite master port.
// One transaction is outstanding at a time; the response and error flag go back to the granted channel.
module bridge_mc #(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          C_in_valid,
  input  logic [N_CH*ADDR_W-1:0]   C_addr,
  input  logic [N_CH*DATA_W-1:0]   C_data_w,
  input  logic [N_CH-1:0]          C_r_wb,
  output logic [N_CH-1:0]          C_busy,
  output logic [N_CH-1:0]          C_out_valid,
  output logic [DATA_W-1:0]        C_data_r,
  output logic                     C_err,
  output logic                     AR_VALID,
  output logic [ADDR_W-1:0]        AR_ADDR,
  input  logic                     AR_READY,
  input  logic                     R_VALID,
  input  logic [DATA_W-1:0]        R_DATA,
  input  logic [1:0]               R_RESP,
  output logic                     R_READY,
  output logic                     AW_VALID,
  output logic [ADDR_W-1:0]        AW_ADDR,
  input  logic                     AW_READY,
  output logic                     W_VALID,
  output logic [DATA_W-1:0]        W_DATA,
  input  logic                     W_READY,
  input  logic                     B_VALID,
  input  logic [1:0]               B_RESP,
  output logic                     B_READY
);

  localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR, S_WR_RESP, S_DONE
  } state_e;

  state_e                         state_q, state_d;
  logic [CH_W-1:0]                last_q, last_d;
  logic [CH_W-1:0]                gnt_q, gnt_d;
  logic [N_CH-1:0]                busy_q, busy_d;
  logic [N_CH-1:0]                rwb_q, rwb_d;
  logic [N_CH-1:0][ADDR_W-1:0]    addr_q, addr_d;
  logic [N_CH-1:0][DATA_W-1:0]    data_q, data_d;
  logic [N_CH-1:0]                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]              data_r_q, data_r_d;
  logic                           err_q, err_d;
  logic                           ar_valid_q, ar_valid_d;
  logic [ADDR_W-1:0]              ar_addr_q, ar_addr_d;
  logic                           r_ready_q, r_ready_d;
  logic                           aw_valid_q, aw_valid_d;
  logic [ADDR_W-1:0]              aw_addr_q, aw_addr_d;
  logic                           w_valid_q, w_valid_d;
  logic [DATA_W-1:0]              w_data_q, w_data_d;
  logic                           b_ready_q, b_ready_d;

  logic                           sel_found;
  logic [CH_W-1:0]                sel;
  int unsigned                    scan_idx;

  // Round-robin scan of registered pending requests, starting after the last grant
  always_comb begin
    sel_found = 1'b0;
    sel       = last_q;
    scan_idx  = 0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      scan_idx = (32'(last_q) + k) % N_CH;
      if (!sel_found && busy_q[CH_W'(scan_idx)]) begin
        sel_found = 1'b1;
        sel       = CH_W'(scan_idx);
      end
    end
  end

  // Holding-register capture plus next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    busy_d      = busy_q;
    rwb_d       = rwb_q;
    addr_d      = addr_q;
    data_d      = data_q;
    out_valid_d = '0;
    data_r_d    = data_r_q;
    err_d       = err_q;
    ar_valid_d  = ar_valid_q;
    ar_addr_d   = ar_addr_q;
    r_ready_d   = r_ready_q;
    aw_valid_d  = aw_valid_q;
    aw_addr_d   = aw_addr_q;
    w_valid_d   = w_valid_q;
    w_data_d    = w_data_q;
    b_ready_d   = b_ready_q;

    for (int unsigned i = 0; i < N_CH; i++) begin
      if (C_in_valid[i] && !busy_q[i]) begin
        busy_d[i] = 1'b1;
        rwb_d[i]  = C_r_wb[i];
        addr_d[i] = C_addr[i*ADDR_W +: ADDR_W];
        data_d[i] = C_data_w[i*DATA_W +: DATA_W];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          gnt_d  = sel;
          last_d = sel;
          if (rwb_q[sel]) begin
            state_d    = S_RD_ADDR;
            ar_valid_d = 1'b1;
            ar_addr_d  = addr_q[sel];
          end else begin
            state_d    = S_WR;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
            aw_addr_d  = addr_q[sel];
            w_data_d   = data_q[sel];
          end
        end
      end
      S_RD_ADDR: begin
        if (AR_READY) begin
          ar_valid_d = 1'b0;
          r_ready_d  = 1'b1;
          state_d    = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (R_VALID) begin
          r_ready_d          = 1'b0;
          data_r_d           = R_DATA;
          err_d              = |R_RESP;
          out_valid_d[gnt_q] = 1'b1;
          busy_d[gnt_q]      = 1'b0;
          state_d            = S_DONE;
        end
      end
      S_WR: begin
        aw_valid_d = aw_valid_q & ~AW_READY;
        w_valid_d  = w_valid_q & ~W_READY;
        if (!aw_valid_d && !w_valid_d) begin
          b_ready_d = 1'b1;
          state_d   = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (B_VALID) begin
          b_ready_d          = 1'b0;
          data_r_d           = '0;
          err_d              = |B_RESP;
          out_valid_d[gnt_q] = 1'b1;
          busy_d[gnt_q]      = 1'b0;
          state_d            = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      last_q      <= CH_W'(N_CH - 1);
      gnt_q       <= '0;
      busy_q      <= '0;
      rwb_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      out_valid_q <= '0;
      data_r_q    <= '0;
      err_q       <= 1'b0;
      ar_valid_q  <= 1'b0;
      ar_addr_q   <= '0;
      r_ready_q   <= 1'b0;
      aw_valid_q  <= 1'b0;
      aw_addr_q   <= '0;
      w_valid_q   <= 1'b0;
      w_data_q    <= '0;
      b_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      rwb_q       <= rwb_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      data_r_q    <= data_r_d;
      err_q       <= err_d;
      ar_valid_q  <= ar_valid_d;
      ar_addr_q   <= ar_addr_d;
      r_ready_q   <= r_ready_d;
      aw_valid_q  <= aw_valid_d;
      aw_addr_q   <= aw_addr_d;
      w_valid_q   <= w_valid_d;
      w_data_q    <= w_data_d;
      b_ready_q   <= b_ready_d;
    end
  end

  assign C_busy      = busy_q;
  assign C_out_valid = out_valid_q;
  assign C_data_r    = data_r_q;
  assign C_err       = err_q;
  assign AR_VALID    = ar_valid_q;
  assign AR_ADDR     = ar_addr_q;
  assign R_READY     = r_ready_q;
  assign AW_VALID    = aw_valid_q;
  assign AW_ADDR     = aw_addr_q;
  assign W_VALID     = w_valid_q;
  assign W_DATA      = w_data_q;
  assign B_READY     = b_ready_q;

endmodule
